// File: rtl/led_ctrl_if.sv
// Configuration write port for led_ctrl: one strobe plus the channel settings it loads.
interface led_ctrl_if #(
   parameter int unsigned PER_W = 12
) ();
   logic             cfg_wr;
   logic [3:0]       cfg_ch;
   logic [1:0]       cfg_mode;
   logic [PER_W-1:0] cfg_period;
   logic [3:0]       cfg_burst;

   modport master (
      output cfg_wr,
      output cfg_ch,
      output cfg_mode,
      output cfg_period,
      output cfg_burst
   );

   modport slave (
      input cfg_wr,
      input cfg_ch,
      input cfg_mode,
      input cfg_period,
      input cfg_burst
   );
endinterface

// File: rtl/led_ctrl.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/BURST patterns timed by a shared
// free-running tick prescaler.
module led_ctrl #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned TICK_DIV    = 12500,
   parameter int unsigned PER_W       = 12,
   parameter int unsigned GAP_PERIODS = 4,
   parameter bit          ACT_LOW     = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   led_ctrl_if.slave       cfg,
   output logic [N_CH-1:0] led_out,
   output logic            tick_o
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned GAP_W = (GAP_PERIODS > 1) ? $clog2(GAP_PERIODS) : 1;

   localparam logic [1:0] ModeOff   = 2'd0;
   localparam logic [1:0] ModeOn    = 2'd1;
   localparam logic [1:0] ModeBlink = 2'd2;
   localparam logic [1:0] ModeBurst = 2'd3;

   typedef enum logic [1:0] {
      StOnPh,
      StOffPh,
      StGap
   } burst_st_e;

   logic [CNT_W-1:0] div_q;

   logic [1:0]       mode_q  [N_CH];
   logic [1:0]       mode_d  [N_CH];
   logic [PER_W-1:0] per_q   [N_CH];
   logic [PER_W-1:0] per_d   [N_CH];
   logic [3:0]       burst_q [N_CH];
   logic [3:0]       burst_d [N_CH];
   logic [PER_W-1:0] phase_q [N_CH];
   logic [PER_W-1:0] phase_d [N_CH];
   logic [3:0]       flash_q [N_CH];
   logic [3:0]       flash_d [N_CH];
   logic [GAP_W-1:0] gap_q   [N_CH];
   logic [GAP_W-1:0] gap_d   [N_CH];
   burst_st_e        st_q    [N_CH];
   burst_st_e        st_d    [N_CH];
   logic [N_CH-1:0]  lit_q;
   logic [N_CH-1:0]  lit_d;
   logic [N_CH-1:0]  wr_hit;
   logic [N_CH-1:0]  evt;

   // Free-running; tick_o is the registered wrap of the divider.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q  <= '0;
         tick_o <= 1'b0;
      end else begin
         div_q  <= (div_q == CNT_W'(TICK_DIV - 1)) ? '0 : div_q + CNT_W'(1);
         tick_o <= (div_q == CNT_W'(TICK_DIV - 1));
      end
   end

   // A period of 0 behaves as 1, so the event compare is against max(per,1)-1.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         wr_hit[i] = cfg.cfg_wr && (cfg.cfg_ch == 4'(i));
         evt[i]    = tick_o &&
                     (phase_q[i] == ((per_q[i] == '0) ? '0 : per_q[i] - PER_W'(1)));
      end
   end

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         mode_d[i]  = mode_q[i];
         per_d[i]   = per_q[i];
         burst_d[i] = burst_q[i];
         phase_d[i] = phase_q[i];
         flash_d[i] = flash_q[i];
         gap_d[i]   = gap_q[i];
         st_d[i]    = st_q[i];
         lit_d[i]   = lit_q[i];

         if (wr_hit[i]) begin
            // A write wins over a coincident tick for its own channel.
            mode_d[i]  = cfg.cfg_mode;
            per_d[i]   = cfg.cfg_period;
            burst_d[i] = cfg.cfg_burst;
            phase_d[i] = '0;
            flash_d[i] = '0;
            gap_d[i]   = '0;
            st_d[i]    = StOnPh;
            lit_d[i]   = 1'b0;
         end else begin
            if (tick_o) begin
               phase_d[i] = evt[i] ? '0 : phase_q[i] + PER_W'(1);
            end

            unique case (mode_q[i])
               ModeOff:   lit_d[i] = 1'b0;
               ModeOn:    lit_d[i] = 1'b1;
               ModeBlink: begin
                  if (evt[i]) begin
                     lit_d[i] = ~lit_q[i];
                  end
               end
               ModeBurst: begin
                  if (burst_q[i] == 4'd0) begin
                     // Zero-flash groups park the channel dark in the gap.
                     st_d[i]    = StGap;
                     flash_d[i] = '0;
                     gap_d[i]   = '0;
                  end else if (evt[i]) begin
                     unique case (st_q[i])
                        StOnPh: begin
                           flash_d[i] = flash_q[i] + 4'd1;
                           st_d[i]    = StOffPh;
                        end
                        StOffPh: begin
                           st_d[i] = (flash_q[i] == burst_q[i]) ? StGap : StOnPh;
                        end
                        default: begin
                           if (gap_q[i] == GAP_W'(GAP_PERIODS - 1)) begin
                              gap_d[i]   = '0;
                              flash_d[i] = '0;
                              st_d[i]    = StOnPh;
                           end else begin
                              gap_d[i] = gap_q[i] + GAP_W'(1);
                           end
                        end
                     endcase
                  end
                  lit_d[i] = (st_d[i] == StOnPh);
               end
               default: lit_d[i] = 1'b0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_CH; i++) begin
            mode_q[i]  <= ModeOff;
            per_q[i]   <= PER_W'(1);
            burst_q[i] <= '0;
            phase_q[i] <= '0;
            flash_q[i] <= '0;
            gap_q[i]   <= '0;
            st_q[i]    <= StOnPh;
         end
         lit_q   <= '0;
         led_out <= {N_CH{ACT_LOW}};
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            mode_q[i]  <= mode_d[i];
            per_q[i]   <= per_d[i];
            burst_q[i] <= burst_d[i];
            phase_q[i] <= phase_d[i];
            flash_q[i] <= flash_d[i];
            gap_q[i]   <= gap_d[i];
            st_q[i]    <= st_d[i];
         end
         lit_q   <= lit_d;
         led_out <= lit_q ^ {N_CH{ACT_LOW}};
      end
   end

endmodule

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 Parameter N_CH, default 4: number of independent LED channels (1..16).
REQ-002 Parameter TICK_DIV, default 12500: clk cycles per timing tick (>=2).
REQ-003 Parameter PER_W, default 12: width of the per-channel period field, in ticks.
REQ-004 Parameter GAP_PERIODS, default 4: number of periods in the dark gap between BURST groups (>=1).
REQ-005 Parameter ACT_LOW, default 1: 1 means lit = 0 on led_out, dark = 1.
REQ-006 clk  input  1  sole clock; all logic samples on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 cfg_wr  input  1  one-cycle configuration write strobe.
REQ-009 cfg_ch  input  4  target channel index of the write.
REQ-010 cfg_mode  input  2  mode code: 0 OFF, 1 ON, 2 BLINK, 3 BURST.
REQ-011 cfg_period  input  PER_W  phase length in ticks; a value of 0 is treated as 1.
REQ-012 cfg_burst  input  4  flashes per BURST group.
REQ-013 led_out  output  N_CH  registered LED drive, one bit per channel.
REQ-014 tick_o  output  1  registered one-cycle pulse, once per tick.

Function
REQ-015 Prescaler counts 0..TICK_DIV-1 and wraps; tick_o is high for exactly the one clk cycle after the count reaches TICK_DIV-1.
REQ-016 Each channel holds mode, period and burst registers, a PER_W-bit phase counter, a 4-bit flash counter, a gap counter and a lit flag.
REQ-017 Registers of channel cfg_ch load on the edge that samples cfg_wr=1; a cfg_ch >= N_CH is ignored with no state change.
REQ-018 A write clears that channel's phase, flash and gap counters and its lit flag, and sets its BURST state to ON_PH.
REQ-019 Channels other than cfg_ch are unaffected by a write.
REQ-020 A channel "event" occurs on a tick where its phase counter equals eff_period-1; the counter then wraps to 0, otherwise it increments on each tick.
REQ-021 OFF: lit flag = 0 at all times.
REQ-022 ON: lit flag = 1 at all times.
REQ-023 BLINK: lit flag toggles on each event, starting dark after a write.
REQ-024 BURST FSM state ON_PH (lit): on an event, increment the flash counter and go to OFF_PH.
REQ-025 BURST FSM state OFF_PH (dark): on an event, go to GAP if the flash counter equals cfg_burst, else go to ON_PH.
REQ-026 BURST FSM state GAP (dark): on event number GAP_PERIODS, clear the flash counter and go to ON_PH.
REQ-027 BURST with cfg_burst = 0: the channel stays dark and its FSM stays in GAP.
REQ-028 led_out[i] = lit_i XOR ACT_LOW, registered one stage after the lit flag.
REQ-029 Latency: led_out reflects a new mode exactly 2 clk edges after the edge that samples cfg_wr.
REQ-030 A write landing on the same cycle as a tick takes priority; that tick does not advance the written channel.
REQ-031 The prescaler is free-running and is never reset by writes.

Reset
REQ-032 While rst = 0, all of the following hold asynchronously: prescaler = 0, tick_o = 0, and every channel has mode OFF, period 1, burst 0, all counters 0 and lit = 0.
REQ-033 While rst = 0, led_out = {N_CH{ACT_LOW}}, i.e. all ones by default (all channels dark).
REQ-034 Reset asserted mid-operation aborts any phase or burst in progress.
REQ-035 After rst is released, the first tick_o fires TICK_DIV clk cycles later.

Verification (TICK_DIV=4, N_CH=4, ACT_LOW=1)
REQ-036 Reset release, no writes -> led_out = 4'b1111 held; tick_o pulses every 4 clk.
REQ-037 Write ch1 ON -> led_out[1] = 0 two clk later; other bits stay 1.
REQ-038 Write ch0 BLINK, period 3 -> led_out[0] toggles every 12 clk, first going low after the 3rd tick.
REQ-039 Write ch2 BURST, period 1, burst 2 -> pattern lit,dark,lit,dark then 4 ticks dark, repeating; write burst 0 -> stays dark.
REQ-040 cfg_wr coincident with tick_o, and cfg_ch = 7 -> no advance for the written channel; the invalid write has no effect.
REQ-041 rst pulsed low mid-BURST -> led_out = 4'b1111 immediately (asynchronous); all modes return to OFF.
